// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by `define MADD_EN.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic is_mul_in;
  logic is_div_in;

  always_comb begin
    is_mul_in = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MADD_EN
    is_mul_in = is_mul_in || (op == OP_MADD) || (op == OP_MADDU)
             || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    is_div_in = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Result datapath, purely combinational from the latched operands
  logic          mul_sgn;
  logic [W2-1:0] ext_a, ext_b, prod;
  logic [W2-1:0] acc_add, acc_sub;

  always_comb begin
    mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a   = mul_sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = mul_sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ext_a * ext_b;
    acc_add = {hi_q, lo_q} + prod;
    acc_sub = {hi_q, lo_q} - prod;
  end

  // Divide on magnitudes so the most-negative / -1 case wraps cleanly
  logic             div_sgn, neg_a, neg_b, div_ok;
  logic [WIDTH-1:0] mag_a, mag_b, dvs, uq, ur, quot, rem;

  always_comb begin
    div_sgn = (op_q == OP_DIV);
    neg_a   = div_sgn & a_q[WIDTH-1];
    neg_b   = div_sgn & b_q[WIDTH-1];
    mag_a   = neg_a ? -a_q : a_q;
    mag_b   = neg_b ? -b_q : b_q;
    div_ok  = (b_q != '0);
    dvs     = div_ok ? mag_b : {{(WIDTH-1){1'b0}}, 1'b1};
    uq      = mag_a / dvs;
    ur      = mag_a % dvs;
    quot    = (neg_a ^ neg_b) ? -uq : uq;
    rem     = neg_a ? -ur : ur;
  end

  logic          wr_en;
  logic [W2-1:0] res;

  always_comb begin
    wr_en = 1'b1;
    res   = prod;
    unique case (1'b1)
      (op_q == OP_DIV) || (op_q == OP_DIVU): begin
        wr_en = div_ok;
        res   = {rem, quot};
      end
      (op_q == OP_MADD) || (op_q == OP_MADDU): res = acc_add;
      (op_q == OP_MSUB) || (op_q == OP_MSUBU): res = acc_sub;
      default: res = prod;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul_in || is_div_in: begin
              op_d    = op;
              a_d     = num1;
              b_d     = num2;
              cnt_d   = is_div_in ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state_d = S_RUN;
            end
            op == OP_MTHI: hi_d = num1;
            op == OP_MTLO: lo_d = num1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (wr_en) begin
            hi_d = res[W2-1:WIDTH];
            lo_d = res[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
